// File: rtl/irq_timer_pkg.sv
// rtl/irq_timer_pkg.sv - register map, CTRL fields, MODE codes and FSM states for irq_timer (IRQ_TIMER_PRESCALE_EN)
package irq_timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PS_LSB   = 4;
    localparam int PS_W          = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Only implemented CTRL bits are stored; everything else reads back as 0
`ifdef IRQ_TIMER_PRESCALE_EN
    localparam logic [31:0] CTRL_WMASK = 32'h0000_00FF;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_000F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    function automatic logic is_auto(input logic [31:0] ctrl);
        return ctrl[CTRL_MODE_LSB +: 2] == MODE_AUTO;
    endfunction

endpackage

// File: rtl/irq_timer_prescaler.sv
// rtl/irq_timer_prescaler.sv - divide-by-(PS+1) tick generator for the count phase
module irq_timer_prescaler
    import irq_timer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            run_i,
    input  logic [PS_W-1:0] ps_i,
    output logic            tick_o
);

    logic [PS_W-1:0] div_q, div_d;

    assign tick_o = run_i && (div_q == ps_i);

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (run_i) begin
            div_d = tick_o ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - CPU-programmable countdown timer with registered interrupt (optional prescaler: IRQ_TIMER_PRESCALE_EN)
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e      state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;
    logic        wr_ctrl, wr_preset, en_now, tick, fsm_set, fsm_clr;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);
    // A CTRL write clearing EN freezes COUNT on the same edge it lands
    assign en_now    = wr_ctrl ? wdata[CTRL_EN] : ctrl_q[CTRL_EN];

`ifdef IRQ_TIMER_PRESCALE_EN
    irq_timer_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q == ST_LOAD),
        .run_i  ((state_q == ST_CNT) && en_now),
        .ps_i   (ctrl_q[CTRL_PS_LSB +: PS_W]),
        .tick_o (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        fsm_set  = 1'b0;
        fsm_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_now) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    // PRESET=0 behaves as 1: expiry on the first counting tick
                    if (count_q <= 32'd1) begin
                        count_d = '0;
                        fsm_set = 1'b1;
                        state_d = ST_INT;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            ST_INT: begin
                if (is_auto(ctrl_q)) begin
                    fsm_clr = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU write overrides the FSM's EN clear on the same edge
        if (wr_ctrl) begin
            ctrl_d = wdata & CTRL_WMASK;
        end
        if (wr_preset) begin
            preset_d = wdata;
        end

        flag_d = flag_q;
        if (wr_ctrl || wr_preset || fsm_clr) begin
            flag_d = 1'b0;
        end
        if (fsm_set) begin
            flag_d = 1'b1;
        end
        irq_d = ctrl_d[CTRL_IM] & flag_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= RESET_PRESET;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = ctrl_q;
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_irq_timer.sv
// tb/tb_irq_timer.sv - directed and randomized bench for irq_timer (IRQ_TIMER_PRESCALE_EN)
module tb_irq_timer;

    localparam logic [31:0] RST_PRESET = 32'h0000_0005;
    localparam logic [1:0]  A_CTRL = 2'd0, A_PRESET = 2'd1, A_COUNT = 2'd2, A_RSVD = 2'd3;
`ifdef IRQ_TIMER_PRESCALE_EN
    localparam logic [31:0] MASK = 32'h0000_00FF;
`else
    localparam logic [31:0] MASK = 32'h0000_000F;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    irq_timer #(.RESET_PRESET(RST_PRESET)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, cw, exp_cnt;
        int p, ps, mode, im, s, pp, e, j, nk;
        bit autom, exp_irq;

        reset = 1'b0; we = 1'b0; addr = A_CTRL; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_irq", irq, 0);
        rd(A_CTRL, v);   check("rst_ctrl", v, 0);
        rd(A_PRESET, v); check("rst_preset", v, RST_PRESET);
        rd(A_COUNT, v);  check("rst_count", v, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Register map: COUNT and reserved writes ignored, unimplemented CTRL bits read 0
        wr(A_COUNT, 32'hDEAD_BEEF);
        rd(A_COUNT, v);  check("count_wr_ignored", v, 0);
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd(A_RSVD, v);   check("rsvd_reads_0", v, 0);
        rd(A_PRESET, v); check("rsvd_wr_no_alias", v, RST_PRESET);
        wr(A_CTRL, 32'hFFFF_FFFE);
        rd(A_CTRL, v);   check("ctrl_mask", v, 32'hFFFF_FFFE & MASK);
        wr(A_CTRL, 32'h0);
        repeat (2) step();

        // One-shot: PRESET=3 -> irq at edge 5, held; EN clears one cycle after INT
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            step();
            check("os_irq", irq, (k >= 5) ? 1 : 0);
            if (k == 5) begin rd(A_CTRL, v); check("os_en_at_int", v, 32'h9); end
            if (k == 6) begin
                rd(A_CTRL, v);  check("os_en_cleared", v, 32'h8);
                rd(A_COUNT, v); check("os_count_0", v, 0);
            end
        end
        wr(A_CTRL, 32'h0);
        step();
        check("os_cleared_by_ctrl_wr", irq, 0);

        // Auto-reload: one-cycle pulses every 5 cycles
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            step();
            check("ar_irq", irq, (k % 5 == 0) ? 1 : 0);
        end
        wr(A_CTRL, 32'h0);
        repeat (4) step();

        // Mask: expiry with IM=0, then enabling IM alone must not expose the flag
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("mask_irq_low", irq, 0);
        end
        rd(A_COUNT, v); check("mask_count_0", v, 0);
        wr(A_CTRL, 32'h8);
        for (int k = 0; k < 4; k++) begin
            check("mask_im_set_irq_low", irq, 0);
            step();
        end

        // Stop mid-count at COUNT=7: COUNT freezes, no irq
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        repeat (5) step();
        rd(A_COUNT, v); check("stop_count_before", v, 7);
        wr(A_CTRL, 32'h8);
        for (int k = 0; k < 6; k++) begin
            rd(A_COUNT, v); check("stop_count_held", v, 7);
            check("stop_irq_low", irq, 0);
            step();
        end

        // PRESET write clears a held one-shot irq
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h9);
        repeat (3) step();
        check("p1_irq_at_3", irq, 1);
        repeat (2) step();
        check("p1_irq_held", irq, 1);
        wr(A_PRESET, 32'd5);
        check("preset_wr_clears_irq", irq, 0);
        step();
        check("preset_wr_irq_stays_low", irq, 0);

        // CTRL write on the one-shot INT edge wins over the EN clear
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h9);
        repeat (3) step();
        check("prio_irq_at_int", irq, 1);
        wr(A_CTRL, 32'hB);
        rd(A_CTRL, v); check("prio_ctrl_kept", v, 32'hB);
        check("prio_irq_cleared", irq, 0);
        step(); check("prio_k5", irq, 0);
        step(); check("prio_k6", irq, 0);
        step(); check("prio_k7_restart", irq, 1);
        step(); check("prio_k8_pulse", irq, 0);
        wr(A_CTRL, 32'h0);
        repeat (4) step();

        // Asynchronous reset mid-count
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        repeat (5) step();
        rd(A_COUNT, v); check("arst_count_before", v, 2);
        reset = 1'b0;
        #1;
        check("arst_irq", irq, 0);
        rd(A_COUNT, v);  check("arst_count", v, 0);
        rd(A_CTRL, v);   check("arst_ctrl", v, 0);
        rd(A_PRESET, v); check("arst_preset", v, RST_PRESET);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("arst_no_pulse", irq, 0);
            rd(A_COUNT, v); check("arst_count_idle", v, 0);
        end

`ifdef IRQ_TIMER_PRESCALE_EN
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h19);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("ps_irq", irq, (k >= 6) ? 1 : 0);
        end
        wr(A_CTRL, 32'h0);
        repeat (4) step();
`endif

        // Randomized trials against an arithmetic timeline of the timer
        for (int t = 0; t < 24; t++) begin
            p    = $urandom_range(0, 6);
            ps   = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            im   = $urandom_range(0, 1);
            cw   = 32'((ps << 4) | (im << 3) | (mode << 1) | 1);
`ifdef IRQ_TIMER_PRESCALE_EN
            s = ps + 1;
`else
            s = 1;
`endif
            pp    = (p == 0) ? 1 : p;
            autom = (mode == 1);
            e     = pp * s + 2;
            nk    = 3 * e + 1;
            wr(A_PRESET, 32'(p));
            wr(A_CTRL, cw);
            for (int k = 1; k <= nk; k++) begin
                step();
                exp_irq = 1'b0;
                if (k >= 2) begin
                    j = autom ? (k - 2) % e : k - 2;
                    exp_irq = (im == 1) && (autom ? (j == pp * s) : (j >= pp * s));
                    exp_cnt = (j < pp * s) ? 32'(p - j / s) : 32'd0;
                    rd(A_COUNT, v);
                    check("rnd_count", v, exp_cnt);
                end
                check("rnd_irq", irq, exp_irq);
            end
            rd(A_CTRL, v);
            check("rnd_ctrl", v, autom ? (cw & MASK) : (cw & MASK & ~32'h1));
            wr(A_CTRL, 32'h0);
            repeat (4) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_timer.md
IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 SHALL have parameter RESET_PRESET, default 32'h0000_0000, giving the PRESET value loaded at reset.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port addr, input, 2 bits: word select (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved).
REQ-005 SHALL have port we, input, 1 bit: write strobe, sampled on a rising clk edge.
REQ-006 SHALL have port wdata, input, 32 bits: write data.
REQ-007 SHALL have port rdata, output, 32 bits: read data, combinational from addr.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request to the CPU, registered.

Function
REQ-009 SHALL decode CTRL as follows: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask), all other bits reading 0.
REQ-010 SHALL store writes to CTRL and PRESET, ignore writes to COUNT and to reserved address 3, and return 0 when reserved address 3 is read.
REQ-011 SHALL implement states IDLE, LOAD, CNT and INT.
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT: if EN=0, go to IDLE with COUNT held; else if COUNT<=1, set COUNT=0 and flag=1 and go to INT; else COUNT-1.
- INT: in one-shot, clear EN and go to IDLE, with the flag held; in auto-reload, clear the flag and go to LOAD.
REQ-012 SHALL drive irq = IM & flag, registered, so that irq rises PRESET+2 edges after the EN write edge for PRESET>=1.
REQ-013 SHALL treat PRESET=0 as PRESET=1, so that INT is entered on the first CNT cycle.
REQ-014 SHALL hold the flag in one-shot mode until the next write to CTRL or PRESET.
REQ-015 SHALL assert irq for exactly one cycle per expiry in auto-reload mode, with period PRESET+2 cycles.
REQ-016 SHALL keep the running COUNT unchanged on a PRESET write during CNT; the new value takes effect at the next LOAD.
REQ-017 SHALL give a CPU CTRL write priority over the FSM's EN clear when both occur on the same edge.
REQ-018 SHALL compute COUNT decrement modulo 2^32 and never underflow below 0.

Reset
REQ-019 SHALL, on reset low, asynchronously set state=IDLE, CTRL=0, PRESET=RESET_PRESET, COUNT=0, flag=0 and irq=0.
REQ-020 SHALL, when reset is asserted mid-count, abort immediately with no irq pulse on release.

Configuration
REQ-021 SHALL, with IRQ_TIMER_PRESCALE_EN defined, use CTRL[7:4]=PS so that CNT decrements only once every PS+1 clk cycles, with the divider reset on entry to LOAD.
REQ-022 SHALL, with IRQ_TIMER_PRESCALE_EN undefined, decrement every cycle, ignore writes to CTRL[7:4] and read CTRL[7:4] as 0.

Structure
REQ-023 SHALL place the register offsets, CTRL bit positions, MODE encodings and state encoding in a shared package irq_timer_pkg.
REQ-024 SHALL implement the prescale divider as sub-module irq_timer_prescaler, instantiated only under IRQ_TIMER_PRESCALE_EN.

Verification
REQ-025 SHALL cover one-shot: PRESET=3, then CTRL=0x9 -> irq high 5 edges later, held; COUNT reads 0; EN reads 0 one cycle after INT.
REQ-026 SHALL cover auto-reload: PRESET=3, CTRL=0xB -> irq 1-cycle pulses every 5 cycles, at least 4 pulses checked.
REQ-027 SHALL cover the mask: PRESET=2, CTRL=0x1 -> irq stays 0; a later write CTRL=0x8 -> irq stays 0, because the CTRL write clears the flag.
REQ-028 SHALL cover stop/clear: mid-count with COUNT=7, write CTRL=0x8 -> state IDLE, COUNT holds 7, no irq; a write to PRESET while one-shot irq is high -> irq low next cycle.
REQ-029 SHALL cover reset: assert reset low while COUNT=2 -> irq, COUNT and CTRL are 0 immediately, without waiting for clk.
REQ-030 SHALL cover prescale (macro defined): PRESET=2, CTRL=0x19 (PS=1) -> irq rises 2+2*2=6 edges after the write.
